// File: rtl/swap_tim_rx.sv
// Far-end receiver for the swap_tim sync stream: measures line timing
// (sync width, gate delay, gate length, line length), lines per frame and lock.
module swap_tim_rx #(
  parameter int CW         = 16,
  parameter int LOCK_LINES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          daten,
  output logic [CW-1:0] meas_hsync,
  output logic [CW-1:0] meas_gdel,
  output logic [CW-1:0] meas_gate,
  output logic [CW-1:0] meas_hlen,
  output logic [CW-1:0] lines,
  output logic          meas_valid,
  output logic          frame_start,
  output logic          locked,
  output logic          err
);

  localparam logic [CW-1:0] CMAX     = {CW{1'b1}};
  localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO     = {CW{1'b0}};
  localparam logic [3:0]    LOCK_MAX = 4'(LOCK_LINES);

  logic          hs_q, vs_q, de_q;
  logic [CW-1:0] hcnt_r, vcnt_r;
  logic          ovf_r;
  logic [CW-1:0] w_r, d_r, f_r;
  logic          w_seen_r, d_seen_r, f_seen_r;
  logic          started_r;
  logic [3:0]    lock_cnt_r;

  logic          hs_rise_s, hs_fall_s, vs_rise_s, de_rise_s, de_fall_s;
  logic          meas_ok_s, commit_s, bad_s, same_s;
  logic [CW-1:0] gdel_s, gate_s;
  logic [3:0]    lock_nxt_s;

  assign hs_rise_s = ena &  hsync & ~hs_q;
  assign hs_fall_s = ena & ~hsync &  hs_q;
  assign vs_rise_s = ena &  vsync & ~vs_q;
  assign de_rise_s = ena &  daten & ~de_q;
  assign de_fall_s = ena & ~daten &  de_q;

  assign gdel_s    = d_r - w_r;
  assign gate_s    = f_r - d_r;
  assign meas_ok_s = w_seen_r & d_seen_r & f_seen_r & ~ovf_r & (w_r < d_r) & (d_r < f_r);
  // The first rise after reset only opens a line, so it neither commits nor errors.
  assign commit_s  = hs_rise_s & started_r &  meas_ok_s;
  assign bad_s     = hs_rise_s & started_r & ~meas_ok_s;
  assign same_s    = (w_r == meas_hsync) && (gdel_s == meas_gdel) &&
                     (gate_s == meas_gate) && (hcnt_r == meas_hlen);

  // Next lock count from the commit/err outcome of this tick.
  always_comb begin
    lock_nxt_s = lock_cnt_r;
    if (bad_s) begin
      lock_nxt_s = 4'd0;
    end else if (commit_s) begin
      if (!same_s) begin
        lock_nxt_s = 4'd1;
      end else if (lock_cnt_r < LOCK_MAX) begin
        lock_nxt_s = lock_cnt_r + 4'd1;
      end else begin
        lock_nxt_s = lock_cnt_r;
      end
    end else begin
      lock_nxt_s = lock_cnt_r;
    end
  end

  // Input history; resets high so a sync held through reset is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b1;
    end else if (ena) begin
      hs_q <= hsync;
      vs_q <= vsync;
      de_q <= daten;
    end
  end

  // Line counter with sticky overflow, restarted by each hsync rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r    <= ZERO;
      ovf_r     <= 1'b0;
      started_r <= 1'b0;
    end else if (hs_rise_s) begin
      hcnt_r    <= ONE;
      ovf_r     <= 1'b0;
      started_r <= 1'b1;
    end else if (ena) begin
      if (hcnt_r == CMAX) begin
        ovf_r <= 1'b1;
      end else begin
        hcnt_r <= hcnt_r + ONE;
      end
    end
  end

  // First-occurrence edge capture within the current line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_r      <= ZERO;
      d_r      <= ZERO;
      f_r      <= ZERO;
      w_seen_r <= 1'b0;
      d_seen_r <= 1'b0;
      f_seen_r <= 1'b0;
    end else if (hs_rise_s) begin
      w_seen_r <= 1'b0;
      d_seen_r <= 1'b0;
      f_seen_r <= 1'b0;
    end else begin
      if (hs_fall_s && !w_seen_r) begin
        w_r      <= hcnt_r;
        w_seen_r <= 1'b1;
      end
      if (de_rise_s && !d_seen_r) begin
        d_r      <= hcnt_r;
        d_seen_r <= 1'b1;
      end
      if (de_fall_s && !f_seen_r) begin
        f_r      <= hcnt_r;
        f_seen_r <= 1'b1;
      end
    end
  end

  // Measurement outputs, pulses and lock state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_hsync <= ZERO;
      meas_gdel  <= ZERO;
      meas_gate  <= ZERO;
      meas_hlen  <= ZERO;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      lock_cnt_r <= 4'd0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= commit_s;
      err        <= bad_s;
      lock_cnt_r <= lock_nxt_s;
      locked     <= (lock_nxt_s == LOCK_MAX);
      if (commit_s) begin
        meas_hsync <= w_r;
        meas_gdel  <= gdel_s;
        meas_gate  <= gate_s;
        meas_hlen  <= hcnt_r;
      end
    end
  end

  // Frame line counting; a coincident hsync rise counts as line 1 of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcnt_r      <= ZERO;
      lines       <= ZERO;
      frame_start <= 1'b0;
    end else begin
      frame_start <= vs_rise_s;
      if (vs_rise_s) begin
        lines  <= vcnt_r;
        vcnt_r <= hs_rise_s ? ONE : ZERO;
      end else if (hs_rise_s && (vcnt_r != CMAX)) begin
        vcnt_r <= vcnt_r + ONE;
      end
    end
  end

endmodule

// File: tb/tb_swap_tim_rx.sv
// Directed bench for swap_tim_rx: steady timing, frames, error, period change,
// ena freeze and mid-line reset, with ena on every second clock.
module tb_swap_tim_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        daten = 1'b0;
  logic [15:0] meas_hsync, meas_gdel, meas_gate, meas_hlen, lines;
  logic        meas_valid, frame_start, locked, err;

  int n_tests = 0;
  int n_fail  = 0;
  int line_idx = 0;
  int stray = 0;
  logic obs_valid, obs_err, obs_fs;
  logic smp_valid, smp_err, smp_fs;

  swap_tim_rx #(.CW(16), .LOCK_LINES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .hsync(hsync), .vsync(vsync), .daten(daten),
    .meas_hsync(meas_hsync), .meas_gdel(meas_gdel), .meas_gate(meas_gate),
    .meas_hlen(meas_hlen), .lines(lines), .meas_valid(meas_valid),
    .frame_start(frame_start), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  // One ena tick followed by one idle clock; pulses sampled on the negedge after the tick.
  task automatic step(input logic h, input logic v, input logic d);
    @(negedge clk);
    hsync = h; vsync = v; daten = d; ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    smp_valid = meas_valid; smp_err = err; smp_fs = frame_start;
  endtask

  task automatic do_pause();
    hsync = 1'b1; daten = 1'b0; vsync = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (meas_valid || err || frame_start) stray++;
    end
    n_tests++;
    if (meas_hsync !== 16'd16 || meas_gdel !== 16'd4 || meas_gate !== 16'd360 ||
        meas_hlen !== 16'd420 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_hold: got %0d/%0d/%0d/%0d lock=%b, want 16/4/360/420 lock=1",
               meas_hsync, meas_gdel, meas_gate, meas_hlen, locked);
    end
  endtask

  // One line: hsync 16, gdel 4, gate 360; vsync on every 20th line.
  task automatic run_line(input int period, input bit de_on, input int pause_at);
    bit v_line;
    v_line = (line_idx % 20 == 0);
    for (int t = 0; t < period; t++) begin
      if (t == pause_at) do_pause();
      step(t < 16, v_line && (t < 16), de_on && (t >= 20) && (t < 380));
      if (t == 0) begin
        obs_valid = smp_valid; obs_err = smp_err; obs_fs = smp_fs;
      end else if (smp_valid || smp_err || smp_fs) begin
        stray++;
      end
    end
    line_idx++;
  endtask

  task automatic chk_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s line=%0d: got %b want %b", name, line_idx - 1, got, want);
    end
  endtask

  task automatic chk_meas(input string name, input int hlen);
    n_tests++;
    if (meas_hsync !== 16'd16 || meas_gdel !== 16'd4 || meas_gate !== 16'd360 ||
        meas_hlen !== 16'(hlen)) begin
      n_fail++;
      $display("FAIL %s line=%0d: got %0d/%0d/%0d/%0d want 16/4/360/%0d", name, line_idx - 1,
               meas_hsync, meas_gdel, meas_gate, meas_hlen, hlen);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (meas_hsync !== 16'd0 || meas_gdel !== 16'd0 || meas_gate !== 16'd0 ||
        meas_hlen !== 16'd0 || lines !== 16'd0 || meas_valid !== 1'b0 ||
        frame_start !== 1'b0 || locked !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got %0d/%0d/%0d/%0d lines=%0d v=%b fs=%b l=%b e=%b want all 0",
               meas_hsync, meas_gdel, meas_gate, meas_hlen, lines, meas_valid, frame_start,
               locked, err);
    end
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_steady();
    run_line(400, 1'b1, -1);
    chk_bit("first_rise_no_valid", obs_valid, 1'b0);
    chk_bit("first_rise_no_err", obs_err, 1'b0);
    chk_bit("first_frame_start", obs_fs, 1'b1);
    run_line(400, 1'b1, -1);
    chk_bit("second_rise_valid", obs_valid, 1'b1);
    chk_meas("steady_meas", 400);
    chk_bit("steady_unlocked_2", locked, 1'b0);
    run_line(400, 1'b1, -1);
    run_line(400, 1'b1, -1);
    chk_bit("steady_unlocked_4", locked, 1'b0);
    run_line(400, 1'b1, -1);
    chk_bit("steady_locked_5", locked, 1'b1);
    chk_bit("steady_valid_5", obs_valid, 1'b1);
  endtask

  task automatic test_frames();
    while (line_idx < 20) run_line(400, 1'b1, -1);
    chk_bit("no_fs_mid_frame", obs_fs, 1'b0);
    run_line(400, 1'b1, -1);
    chk_bit("fs_line20", obs_fs, 1'b1);
    n_tests++;
    if (lines !== 16'd20) begin
      n_fail++;
      $display("FAIL lines_frame2: got %0d want 20", lines);
    end
    while (line_idx < 41) run_line(400, 1'b1, -1);
    chk_bit("fs_line40", obs_fs, 1'b1);
    n_tests++;
    if (lines !== 16'd20) begin
      n_fail++;
      $display("FAIL lines_frame3: got %0d want 20", lines);
    end
  endtask

  task automatic test_err();
    run_line(400, 1'b0, -1);
    run_line(400, 1'b1, -1);
    chk_bit("err_pulse", obs_err, 1'b1);
    chk_bit("err_no_valid", obs_valid, 1'b0);
    chk_bit("err_unlock", locked, 1'b0);
    chk_meas("err_hold", 400);
    run_line(400, 1'b1, -1);
    chk_bit("err_recover_valid", obs_valid, 1'b1);
    chk_bit("err_recover_noerr", obs_err, 1'b0);
    run_line(400, 1'b1, -1);
    run_line(400, 1'b1, -1);
    chk_bit("relock_not_yet", locked, 1'b0);
    run_line(400, 1'b1, -1);
    chk_bit("relock_4th", locked, 1'b1);
  endtask

  task automatic test_period();
    run_line(420, 1'b1, -1);
    chk_bit("period_still_locked", locked, 1'b1);
    run_line(420, 1'b1, -1);
    chk_bit("period_valid", obs_valid, 1'b1);
    chk_meas("period_meas", 420);
    chk_bit("period_unlock", locked, 1'b0);
    run_line(420, 1'b1, -1);
    run_line(420, 1'b1, -1);
    chk_bit("period_not_yet", locked, 1'b0);
    run_line(420, 1'b1, -1);
    chk_bit("period_relock", locked, 1'b1);
  endtask

  task automatic test_ena_hold();
    run_line(420, 1'b1, 200);
    run_line(420, 1'b1, -1);
    chk_bit("pause_valid", obs_valid, 1'b1);
    chk_bit("pause_no_err", obs_err, 1'b0);
    chk_meas("pause_meas", 420);
    chk_bit("pause_locked", locked, 1'b1);
  endtask

  task automatic test_reset_mid();
    int cnt;
    for (int t = 0; t < 150; t++) step(t < 16, 1'b0, (t >= 20));
    hsync = 1'b1; daten = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (meas_hsync !== 16'd0 || meas_hlen !== 16'd0 || lines !== 16'd0 ||
        locked !== 1'b0 || meas_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got hs=%0d hlen=%0d lines=%0d l=%b v=%b e=%b want 0",
               meas_hsync, meas_hlen, lines, locked, meas_valid, err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int t = 0; t < 5; t++) begin
      step(1'b1, 1'b0, 1'b1);
      if (smp_valid || smp_err) cnt++;
    end
    for (int t = 0; t < 50; t++) begin
      step(1'b0, 1'b0, 1'b0);
      if (smp_valid || smp_err) cnt++;
    end
    chk_bit("release_no_pulse", (cnt != 0), 1'b0);
    line_idx = 1;
    run_line(400, 1'b1, -1);
    chk_bit("rst_first_no_valid", obs_valid, 1'b0);
    chk_bit("rst_first_no_err", obs_err, 1'b0);
    run_line(400, 1'b1, -1);
    chk_bit("rst_second_valid", obs_valid, 1'b1);
    chk_meas("rst_second_meas", 400);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_frames();
    test_err();
    test_period();
    test_ena_hold();
    test_reset_mid();
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL stray_pulses: got %0d want 0", stray);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/swap_tim_rx.md
# swap_tim_rx

Video timing receiver/measurement block that sits at the far end of the `swap_tim` sync stream. It samples `hsync`, `vsync` and `daten` on `ena` ticks and recovers the line timing parameters (sync width, gate delay, gate length, line length) plus lines per frame. It flags lock when the timing is stable and reports malformed lines. Downstream logic uses it to check generated timing and to align buffer swaps to frame starts.

## Interface
- `CW`, 16: width of all counters and measurement outputs.
- `LOCK_LINES`, 4: consecutive identical line measurements required to assert `locked` (range 2..15).

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  pixel tick qualifier; all sampling and counting advance only on `clk` edges with `ena`=1.
- `hsync`  in  1  line sync, active high.
- `vsync`  in  1  frame sync, active high.
- `daten`  in  1  active-data gate, active high.
- `meas_hsync`  out  CW  hsync high width in ticks.
- `meas_gdel`  out  CW  ticks from hsync fall to daten rise.
- `meas_gate`  out  CW  daten high width in ticks.
- `meas_hlen`  out  CW  ticks between consecutive hsync rises.
- `lines`  out  CW  hsync rises counted between consecutive vsync rises.
- `meas_valid`  out  1  one-clk pulse when the four `meas_*` outputs update.
- `frame_start`  out  1  one-clk pulse on a vsync rise.
- `locked`  out  1  timing stable.
- `err`  out  1  one-clk pulse on a malformed line.

## Operation
- Input history registers `hs_q`, `vs_q`, `de_q` load on ena ticks. Edges are combinational: current input vs. `_q` value, qualified by `ena`.
- Line counter `hcnt`:
  - Loads 1 on an hsync rise; otherwise increments on each ena tick.
  - Saturates at 2^CW−1 and sets a sticky `ovf` flag, which clears on the next hsync rise.
- Within a line, edges are captured into scratch registers using the pre-update `hcnt` value:
  - hsync fall → `w` = `hcnt`.
  - daten rise → `d` = `hcnt`.
  - daten fall → `f` = `hcnt`.
  - Per-edge seen flags clear on each hsync rise.
  - Only the first occurrence of each edge per line is captured.
- Commit on the next hsync rise, if all three flags are set, `ovf`=0 and `w<d<f`:
  - `meas_hsync`=`w`, `meas_gdel`=`d−w`, `meas_gate`=`f−d`, `meas_hlen`=`hcnt`.
  - `meas_valid` pulses.
- If the commit condition fails, `err` pulses, outputs hold and `locked` clears.
- The first hsync rise after reset only starts a line: no commit, no err.
- Lock counter:
  - Increments (saturating at `LOCK_LINES`) on a commit whose four values equal the currently held outputs.
  - Loads 1 on a commit with any difference.
  - Loads 0 on err.
  - `locked` = (counter == `LOCK_LINES`).
- Frame counting:
  - `vcnt` increments on each hsync rise.
  - On a vsync rise: `lines`=`vcnt`, `frame_start` pulses, and `vcnt` loads 1 if an hsync rise occurs on the same tick, else 0.
  - The first vsync rise after reset loads `lines` with a partial count; consumers ignore `lines` until the second `frame_start`.
- `ena`=0 freezes all state. Pulse outputs are never asserted on cycles following an `ena`=0 edge.

## Timing
- Reset values: all `meas_*`, `lines`, `hcnt`, `vcnt` = 0; `meas_valid`, `frame_start`, `err`, `locked` = 0.
- `_q` registers reset to 1, so a sync held high through reset does not produce a false rise.
- Latency: the edge is sampled on ena edge N; registered outputs and pulses are valid from edge N (visible after it) for exactly one clk.
- The measured line is reported at the hsync rise that ends it, one line-period after that line's own rise.
- Asynchronous reset mid-line clears everything; measurement restarts at the next hsync rise, with the first line discarded.

## Test plan
- Steady timing (hsync 16, gdel 4, gate 360, period 400 ticks, ena every 2nd clk) → from the 2nd rise `meas_*`=16/4/360/400, `meas_valid` every 800 clks, `locked` set at the 5th hsync rise.
- vsync every 20 lines, with vsync rise coincident with an hsync rise → `lines`=20 from the second `frame_start`, single-cycle `frame_start`.
- One line with daten suppressed → `err` pulse at the following hsync rise, `locked`=0, outputs hold 16/4/360/400, relock after 4 good lines.
- Period change to 420 mid-stream → one commit with hlen=420, lock counter=1, `locked` reasserts 3 lines later.
- Hold `ena`=0 for 1000 clks mid-line → no counter/output change; measurement resumes correctly.
- Assert `rst_n`=0 mid-gate with hsync high → all outputs 0 immediately; no false rise on release; first valid commit at the 2nd hsync rise.
